// File: rtl/pc_control.sv
// pc_control: registered program counter sequencer with NEXT/JUMP/CALL/RET.
// Define PC_CONTROL_STACK_EN to build the return-address stack; otherwise CALL acts as JUMP and RET as NEXT.
`default_nettype none

module pc_control #(
   parameter int WORD_SIZE   = 18,
   parameter int STACK_DEPTH = 8
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           stall,
   input  logic [1:0]                     op,
   input  logic                           if_ok,
   input  logic [WORD_SIZE-1:0]           target,
   output logic [WORD_SIZE-1:0]           pc,
   output logic [$clog2(STACK_DEPTH):0]   sp,
   output logic                           stack_overflow,
   output logic                           stack_underflow
);

   localparam int         SP_W    = $clog2(STACK_DEPTH) + 1;
   localparam logic [1:0] OP_NEXT = 2'd0;
   localparam logic [1:0] OP_JUMP = 2'd1;
   localparam logic [1:0] OP_CALL = 2'd2;
   localparam logic [1:0] OP_RET  = 2'd3;

   logic [WORD_SIZE-1:0] pc_inc;
   logic [WORD_SIZE-1:0] pc_next;

   assign pc_inc = pc + WORD_SIZE'(1);

`ifdef PC_CONTROL_STACK_EN
   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [WORD_SIZE-1:0] stack_mem [STACK_DEPTH];
   logic                 stack_full;
   logic                 stack_empty;
   logic                 call_taken;
   logic                 ret_taken;
   logic                 push;
   logic                 pop;
   logic [PTR_W-1:0]     wr_idx;
   logic [PTR_W-1:0]     top_idx;
   logic [WORD_SIZE-1:0] top_entry;

   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign call_taken  = !stall && (op == OP_CALL) && if_ok;
   assign ret_taken   = !stall && (op == OP_RET) && if_ok;
   assign push        = call_taken && !stack_full;
   assign pop         = ret_taken && !stack_empty;
   assign wr_idx      = PTR_W'(sp);
   assign top_idx     = PTR_W'(sp - SP_W'(1));
   assign top_entry   = stack_mem[top_idx];

   always_comb begin
      pc_next = pc_inc;
      case (op)
         OP_JUMP, OP_CALL: if (if_ok) pc_next = target;
         OP_RET:           if (if_ok && !stack_empty) pc_next = top_entry;
         default:          pc_next = pc_inc;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sp              <= '0;
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         if (push)
            sp <= sp + SP_W'(1);
         else if (pop)
            sp <= sp - SP_W'(1);
         if (call_taken && stack_full)
            stack_overflow <= 1'b1;
         if (ret_taken && stack_empty)
            stack_underflow <= 1'b1;
      end
   end

   // Entries need no reset: they are only readable while sp is non-zero.
   always_ff @(posedge clock) begin
      if (push)
         stack_mem[wr_idx] <= pc_inc;
   end
`else
   always_comb begin
      pc_next = pc_inc;
      case (op)
         OP_JUMP, OP_CALL: if (if_ok) pc_next = target;
         OP_NEXT, OP_RET:  pc_next = pc_inc;
         default:          pc_next = pc_inc;
      endcase
   end

   assign sp              = '0;
   assign stack_overflow  = 1'b0;
   assign stack_underflow = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         pc <= '0;
      else if (!stall)
         pc <= pc_next;
   end

endmodule

`default_nettype wire

// File: tb/tb_pc_control.sv
// tb_pc_control: directed and randomized checks of pc_control against a queue-based model.
`default_nettype none

module tb_pc_control;

   localparam int W = 18;
   localparam int D = 8;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          stall = 1'b0;
   logic [1:0]    op = 2'd0;
   logic          if_ok = 1'b0;
   logic [W-1:0]  target = '0;
   logic [W-1:0]  pc;
   logic [3:0]    sp;
   logic          stack_overflow;
   logic          stack_underflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: pc value, return stack as a queue, sticky flags.
   logic [W-1:0]  m_pc = '0;
   logic [W-1:0]  m_stk[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   pc_control #(.WORD_SIZE(W), .STACK_DEPTH(D)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .stall           (stall),
      .op              (op),
      .if_ok           (if_ok),
      .target          (target),
      .pc              (pc),
      .sp              (sp),
      .stack_overflow  (stack_overflow),
      .stack_underflow (stack_underflow)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      m_pc = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input logic [1:0] o, input logic ok, input logic [W-1:0] t, input logic st);
      logic [W-1:0] inc;
      if (st) return;
      inc = W'((int'(m_pc) + 1) % (1 << W));
`ifdef PC_CONTROL_STACK_EN
      case (o)
         2'd1: m_pc = ok ? t : inc;
         2'd2: begin
            if (ok) begin
               if (m_stk.size() < D) m_stk.push_back(inc);
               else m_ovf = 1'b1;
               m_pc = t;
            end else m_pc = inc;
         end
         2'd3: begin
            if (ok && m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
               if (ok) m_unf = 1'b1;
               m_pc = inc;
            end
         end
         default: m_pc = inc;
      endcase
`else
      if ((o == 2'd1 || o == 2'd2) && ok) m_pc = t;
      else m_pc = inc;
`endif
   endtask

   task automatic check_all(input string tag);
      logic [3:0] exp_sp;
`ifdef PC_CONTROL_STACK_EN
      exp_sp = 4'(m_stk.size());
`else
      exp_sp = 4'd0;
`endif
      n_checks++;
      assert (pc === m_pc) else begin
         n_fail++;
         $error("FAIL %s pc: got %h expected %h", tag, pc, m_pc);
      end
      n_checks++;
      assert (sp === exp_sp) else begin
         n_fail++;
         $error("FAIL %s sp: got %0d expected %0d", tag, sp, exp_sp);
      end
      n_checks++;
      assert (stack_overflow === m_ovf) else begin
         n_fail++;
         $error("FAIL %s overflow: got %b expected %b", tag, stack_overflow, m_ovf);
      end
      n_checks++;
      assert (stack_underflow === m_unf) else begin
         n_fail++;
         $error("FAIL %s underflow: got %b expected %b", tag, stack_underflow, m_unf);
      end
   endtask

   task automatic step(input string tag, input logic [1:0] o, input logic ok,
                       input logic [W-1:0] t, input logic st);
      op = o; if_ok = ok; target = t; stall = st;
      model_step(o, ok, t, st);
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset state, checked before any clock edge.
      #3;
      model_reset();
      check_all("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Three NEXTs from reset, then two more to reach pc=5.
      for (int i = 0; i < 5; i++) step("next", 2'd0, 1'b0, '0, 1'b0);
      n_checks++;
      assert (pc === 18'h5) else begin
         n_fail++;
         $error("FAIL pc_at_5: got %h expected %h", pc, 18'h5);
      end

      step("jump_nottaken", 2'd1, 1'b0, 18'h100, 1'b0);
      n_checks++;
      assert (pc === 18'h6) else begin
         n_fail++;
         $error("FAIL jump_nottaken_abs: got %h expected %h", pc, 18'h6);
      end
      step("jump_taken", 2'd1, 1'b1, 18'h100, 1'b0);

      // CALL then RET around pc=0x10.
      step("jump_0x10", 2'd1, 1'b1, 18'h10, 1'b0);
      step("call_0x40", 2'd2, 1'b1, 18'h40, 1'b0);
      step("ret", 2'd3, 1'b1, 18'h0, 1'b0);
      step("call_nottaken", 2'd2, 1'b0, 18'h55, 1'b0);
      step("ret_nottaken", 2'd3, 1'b0, 18'h0, 1'b0);

      // Nine nested CALLs overflow an 8-deep stack, then eight RETs unwind.
      for (int i = 0; i < 9; i++) step("nested_call", 2'd2, 1'b1, W'(18'h200 + 18'(i * 16)), 1'b0);
      for (int i = 0; i < 8; i++) step("unwind_ret", 2'd3, 1'b1, 18'h0, 1'b0);

      // RET on an empty stack at the top of the address space wraps to 0.
      step("jump_top", 2'd1, 1'b1, 18'h3FFFF, 1'b0);
      step("ret_empty", 2'd3, 1'b1, 18'h0, 1'b0);
      n_checks++;
      assert (pc === 18'h0) else begin
         n_fail++;
         $error("FAIL wrap_to_zero: got %h expected %h", pc, 18'h0);
      end

      // CALL held off by stall, then asynchronous reset mid-cycle.
      step("jump_0x20", 2'd1, 1'b1, 18'h20, 1'b0);
      step("call_push", 2'd2, 1'b1, 18'h80, 1'b0);
      step("stall_call1", 2'd2, 1'b1, 18'h123, 1'b1);
      step("stall_call2", 2'd2, 1'b1, 18'h123, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      @(negedge clock);
      reset_n = 1'b1;
      step("after_reset", 2'd1, 1'b0, 18'h321, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic [1:0]   ro;
         logic         rok;
         logic         rst;
         logic [W-1:0] rt;
         ro  = 2'($urandom_range(0, 3));
         rok = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 7) == 0);
         rt  = W'($urandom);
         step("random", ro, rok, rt, rst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_control.md
PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 18, meaning program counter and target width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 8, meaning the number of return-address stack entries (power of two, 2..32).
REQ-003 SHALL have port clock, input, 1, meaning the single system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, meaning hold all state this cycle when 1.
REQ-006 SHALL have port op, input, 2, meaning 0=NEXT, 1=JUMP, 2=CALL, 3=RET.
REQ-007 SHALL have port if_ok, input, 1, meaning the branch condition from the condition evaluator, valid in the same cycle as op.
REQ-008 SHALL have port target, input, WORD_SIZE, meaning the jump/call destination address.
REQ-009 SHALL have port pc, output, WORD_SIZE, meaning the current fetch address, registered.
REQ-010 SHALL have port sp, output, clog2(STACK_DEPTH)+1, meaning the current stack occupancy, registered.
REQ-011 SHALL have port stack_overflow, output, 1, meaning sticky flag for a CALL taken with the stack full.
REQ-012 SHALL have port stack_underflow, output, 1, meaning sticky flag for a RET taken with the stack empty.

Function
REQ-013 SHALL define pc_inc = pc+1 modulo 2^WORD_SIZE; all-ones SHALL wrap to 0.
REQ-014 SHALL, on a clock edge with stall=0 and op=NEXT, load pc with pc_inc regardless of if_ok.
REQ-015 SHALL, on op=JUMP, load pc with target if if_ok=1, else with pc_inc.
REQ-016 SHALL, on op=CALL with if_ok=1 and sp<STACK_DEPTH, push pc_inc, increment sp, and load pc with target in the same edge.
REQ-017 SHALL, on op=CALL with if_ok=1 and sp==STACK_DEPTH, load pc with target, leave the stack and sp unchanged, and set stack_overflow.
REQ-018 SHALL, on op=RET with if_ok=1 and sp>0, load pc with the top entry and decrement sp.
REQ-019 SHALL, on op=RET with if_ok=1 and sp==0, load pc with pc_inc and set stack_underflow.
REQ-020 SHALL treat CALL or RET with if_ok=0 as NEXT, with no stack change.
REQ-021 SHALL, when stall=1, hold pc, sp, stack contents and flags, ignoring op, if_ok and target.
REQ-022 SHALL have one-edge latency: a decision in cycle N is visible on pc in cycle N+1; there SHALL be no combinational path from inputs to outputs.
REQ-023 SHALL allow back-to-back CALL/RET on consecutive cycles, with each decision using the stack state updated by the previous edge.
REQ-024 SHALL keep stack_overflow and stack_underflow set until reset.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force pc=0, sp=0, stack_overflow=0 and stack_underflow=0.
REQ-026 SHALL NOT be required to clear stack entry contents at reset; entries are unobservable while sp=0.
REQ-027 SHALL, on reset asserted mid-operation (including during stall), abandon all pending state; the first edge after release SHALL act on inputs with pc=0.

Configuration
REQ-028 SHALL, with macro PC_CONTROL_STACK_EN defined, implement the return-address stack per REQ-016..REQ-019.
REQ-029 SHALL, without PC_CONTROL_STACK_EN, implement no stack storage; CALL SHALL behave as JUMP, RET SHALL behave as NEXT, and sp, stack_overflow and stack_underflow SHALL be tied to 0.

Verification
REQ-030 SHALL verify: reset, then 3 edges of NEXT -> pc=0,1,2,3.
REQ-031 SHALL verify: pc=5, JUMP with target=0x100 and if_ok=0 -> pc=6; same op with if_ok=1 -> pc=0x100.
REQ-032 SHALL verify: pc=0x10, CALL to 0x40 -> pc=0x40, sp=1; then RET -> pc=0x11, sp=0.
REQ-033 SHALL verify: 9 nested CALLs with STACK_DEPTH=8 -> sp=8, stack_overflow=1, 9th target reached; then 8 RETs unwind correctly.
REQ-034 SHALL verify: RET with sp=0 at pc=0x3FFFF (WORD_SIZE=18) -> pc=0, stack_underflow=1.
REQ-035 SHALL verify: CALL with stall=1 for 2 cycles, then reset_n pulsed low -> pc and sp unchanged during stall; all outputs 0 immediately on reset.
